// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle 32-bit restoring divider controller for the EX stage
// Optional signed mode: define DIV_SIGNED_EN; otherwise all divisions are unsigned.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] dividend_abs;
  logic [31:0] divisor_abs;
  logic [32:0] trial;
  logic [31:0] rem_step;
  logic [31:0] quo_step;
  logic [31:0] rem_fin;
  logic [31:0] quo_fin;

`ifdef DIV_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;

  always_comb begin
    dividend_abs = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
    divisor_abs  = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
  end
`else
  logic unused_signed_div;
  assign unused_signed_div = signed_div_i;

  always_comb begin
    dividend_abs = opdata1_i;
    divisor_abs  = opdata2_i;
  end
`endif

  // One restoring step: shift the next dividend bit into the partial remainder
  // and keep the difference only when it did not borrow.
  always_comb begin
    trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
    if (!trial[32]) begin
      rem_step = trial[31:0];
      quo_step = {quo_q[30:0], 1'b1};
    end else begin
      rem_step = {rem_q[30:0], quo_q[31]};
      quo_step = {quo_q[30:0], 1'b0};
    end
  end

`ifdef DIV_SIGNED_EN
  always_comb begin
    quo_fin = neg_quo_q ? (32'd0 - quo_step) : quo_step;
    rem_fin = neg_rem_q ? (32'd0 - rem_step) : rem_step;
  end
`else
  always_comb begin
    quo_fin = quo_step;
    rem_fin = rem_step;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    ready_d  = ready_q;
`ifdef DIV_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      FREE: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          rem_d = 32'h0;
          quo_d = dividend_abs;
          dvs_d = divisor_abs;
          cnt_d = 5'd0;
`ifdef DIV_SIGNED_EN
          neg_quo_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d = signed_div_i && opdata1_i[31];
`endif
          state_d = (opdata2_i == 32'h0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        if (annul_i) begin
          state_d = FREE;
        end else begin
          result_d = 64'h0;
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      ON: begin
        if (annul_i) begin
          cnt_d   = 5'd0;
          state_d = FREE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = {rem_fin, quo_fin};
            ready_d  = 1'b1;
            state_d  = END;
          end
        end
      end
      END: begin
        if (!start_i) begin
          result_d = 64'h0;
          ready_d  = 1'b0;
          state_d  = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FREE;
      cnt_q    <= 5'd0;
      rem_q    <= 32'h0;
      quo_q    <= 32'h0;
      dvs_q    <= 32'h0;
      result_q <= 64'h0;
      ready_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
      ready_q  <= ready_d;
`ifdef DIV_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed table-driven bench for div_ctrl (signed or unsigned build)
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic        sgn;
    logic [63:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .result_o     (result_o),
    .ready_o      (ready_o),
    .stallreq_o   (stallreq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s);
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = s;
    start_i      = 1'b1;
  endtask

  // Called on a negedge with start_i already high; edges are counted from the accepting one.
  task automatic wait_ready(input int exp_lat, input logic [63:0] exp_res, input string name);
    int   n = 0;
    logic stall_ok = 1'b1;
    do begin
      #1;
      if (stallreq_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      n++;
    end while (ready_o !== 1'b1 && n < 40);
    chk({name, " stall_pending"}, {63'h0, stall_ok}, 64'h1);
    chk({name, " latency"}, 64'(n), 64'(exp_lat));
    chk({name, " result"}, result_o, exp_res);
    #1;
    chk({name, " stall_done"}, {63'h0, stallreq_o}, 64'h0);
  endtask

  task automatic release_start(input string name);
    start_i = 1'b0;
    @(negedge clk);
    chk({name, " rel_ready"}, {63'h0, ready_o}, 64'h0);
    chk({name, " rel_result"}, result_o, 64'h0);
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic s,
                              input logic [63:0] e, input string nm);
    vec_t v;
    v.op1 = a; v.op2 = b; v.sgn = s; v.exp = e; v.name = nm;
    v.lat = (b == 32'h0) ? 2 : 33;
    return v;
  endfunction

  initial begin
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;

    vecs.push_back(mk(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "u100_7"));
    vecs.push_back(mk(32'd7, 32'd100, 1'b0, {32'd7, 32'd0}, "u7_100"));
    vecs.push_back(mk(32'hFFFFFFFF, 32'd1, 1'b0, {32'd0, 32'hFFFFFFFF}, "umax_1"));
    vecs.push_back(mk(32'd5, 32'd0, 1'b0, 64'h0, "u5_0"));
    vecs.push_back(mk(32'd5, 32'd0, 1'b1, 64'h0, "s5_0"));
    vecs.push_back(mk(32'hFFFFFFF9, 32'd2, 1'b0, {32'd1, 32'h7FFFFFFC}, "u_m7_2"));
`ifdef DIV_SIGNED_EN
    vecs.push_back(mk(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, "s_m7_2"));
    vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, "s_min_m1"));
    vecs.push_back(mk(32'd7, 32'hFFFFFFFE, 1'b1, {32'd1, 32'hFFFFFFFD}, "s_7_m2"));
    vecs.push_back(mk(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFFFE, 32'd14}, "s_m100_m7"));
`else
    vecs.push_back(mk(32'hFFFFFFF9, 32'd2, 1'b1, {32'd1, 32'h7FFFFFFC}, "s_m7_2"));
    vecs.push_back(mk(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h80000000, 32'h0}, "s_min_m1"));
    vecs.push_back(mk(32'd7, 32'hFFFFFFFE, 1'b1, {32'd7, 32'd0}, "s_7_m2"));
    vecs.push_back(mk(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, {32'hFFFFFF9C, 32'd0}, "s_m100_m7"));
`endif

    repeat (2) @(negedge clk);
    chk("reset ready", {63'h0, ready_o}, 64'h0);
    chk("reset result", result_o, 64'h0);
    chk("reset stall", {63'h0, stallreq_o}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      drive(vecs[i].op1, vecs[i].op2, vecs[i].sgn);
      wait_ready(vecs[i].lat, vecs[i].exp, vecs[i].name);
      release_start(vecs[i].name);
    end

    // start together with annul in FREE must not begin a division
    drive(32'd100, 32'd7, 1'b0);
    annul_i = 1'b1;
    #1 chk("both_free stall", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (ready_o) seen = 1'b1;
      end
      chk("both_free no_ready", {63'h0, seen}, 64'h0);
    end

    // annul at step 10
    drive(32'd100, 32'd7, 1'b0);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    #1 chk("annul stall", {63'h0, stallreq_o}, 64'h0);
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    begin
      logic seen = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (ready_o || result_o != 64'h0) seen = 1'b1;
      end
      chk("annul no_ready", {63'h0, seen}, 64'h0);
    end
    drive(32'd9, 32'd3, 1'b0);
    wait_ready(33, {32'd0, 32'd3}, "after_annul 9_3");
    release_start("after_annul");

    // reset at step 20 with start held
    drive(32'd100, 32'd7, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst ready", {63'h0, ready_o}, 64'h0);
    chk("midrst result", result_o, 64'h0);
    rst = 1'b0;
    wait_ready(33, {32'd2, 32'd14}, "midrst restart");
    release_start("midrst");

    // start held in END keeps result stable
    drive(32'd1000, 32'd9, 1'b0);
    wait_ready(33, {32'd1, 32'd111}, "hold 1000_9");
    begin
      logic stable = 1'b1;
      repeat (5) begin
        @(negedge clk);
        if (ready_o !== 1'b1 || result_o !== {32'd1, 32'd111}) stable = 1'b0;
      end
      chk("hold stable", {63'h0, stable}, 64'h1);
    end
    release_start("hold");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset (`RstEnable)
- start_i  in  1  EX requests a division; held high until result consumed
- annul_i  in  1  cancel current/pending division (branch-delay flush)
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend, sampled on accepting edge only
- opdata2_i  in  32  divisor, sampled on accepting edge only
- result_o  out  64  {remainder[63:32], quotient[31:0]}
- ready_o  out  1  result_o valid
- stallreq_o  out  1  pipeline stall request to ctrl
REQ-003 All outputs except stallreq_o SHALL be registered; stallreq_o SHALL be combinational.

Function
REQ-004 The FSM SHALL have four states: FREE, BYZERO, ON, END.
REQ-005 In FREE, start_i=1 and annul_i=0 SHALL latch operands and move to BYZERO if opdata2_i==0, else to ON with iteration counter cleared to 0.
REQ-006 In ON, each edge SHALL perform one restoring shift-subtract step; after the 32nd step, on that same edge, it SHALL register {remainder, quotient} and move to END.
REQ-007 Latency: ready_o SHALL rise exactly 33 edges after the accepting edge for a nonzero divisor, and 2 edges after it for a zero divisor.
REQ-008 BYZERO SHALL move to END on the next edge with result_o = 64'h0.
REQ-009 In END, ready_o SHALL be 1 and result_o held while start_i=1; start_i=0 SHALL return to FREE with ready_o=0 and result_o=0.
REQ-010 annul_i=1 in ON or BYZERO SHALL return to FREE on the next edge; ready_o SHALL stay 0; no partial result is exposed.
REQ-011 Simultaneous start_i and annul_i in FREE SHALL NOT start a division.
REQ-012 Signed mode SHALL divide the absolute values; the quotient SHALL be negated if the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-013 0x80000000 / 0xFFFFFFFF signed SHALL yield quotient 0x80000000, remainder 0 (two's-complement wrap, no trap).
REQ-014 stallreq_o SHALL equal start_i & ~ready_o & ~annul_i.

Reset
REQ-015 When rst=1 at an edge, the state SHALL go to FREE, the counter to 0, result_o to 64'h0 and ready_o to 0, regardless of the current state.
REQ-016 A reset in mid-ON SHALL discard the operation; a held start_i SHALL then be accepted on the first edge with rst=0.

Configuration
REQ-017 With macro DIV_SIGNED_EN defined, signed_div_i SHALL select behaviour per REQ-012.
REQ-018 Without DIV_SIGNED_EN, signed_div_i SHALL be ignored, all divisions SHALL be unsigned, and no sign-correction logic SHALL be synthesized.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Unsigned 100/7 -> after 33 edges ready_o=1, result_o={32'd2, 32'd14}; stallreq_o high until ready.
- DIV_SIGNED_EN, signed 0xFFFFFFF9/2 (-7/2) -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; without the macro the same stimulus -> {32'd1, 32'h7FFFFFFC}.
- Divisor 0 -> ready_o=1 two edges after accept with result_o=64'h0.
- annul_i pulsed at step 10 -> FREE next edge, ready_o never rises; a new start of 9/3 then gives {0, 3} 33 edges later.
- rst asserted at step 20 -> all outputs 0 next edge; held start_i of 100/7 restarts and completes 33 edges after release.
- start_i held 5 cycles after END -> result_o stable; start_i dropped -> ready_o=0, result_o=0 next edge.
